// File: rtl/cpu15_pkg.sv
// Shared cpu15 register-path definitions: widths, write-back buffer states
// and register-number constants.
package cpu15_pkg;

  localparam int REG_W     = 16;
  localparam int REG_NUM_W = 3;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  localparam logic [REG_NUM_W-1:0] R0 = 3'd0;
  localparam logic [REG_NUM_W-1:0] R1 = 3'd1;
  localparam logic [REG_NUM_W-1:0] R2 = 3'd2;
  localparam logic [REG_NUM_W-1:0] R3 = 3'd3;
  localparam logic [REG_NUM_W-1:0] R4 = 3'd4;
  localparam logic [REG_NUM_W-1:0] R5 = 3'd5;
  localparam logic [REG_NUM_W-1:0] R6 = 3'd6;
  localparam logic [REG_NUM_W-1:0] R7 = 3'd7;

endpackage

// File: rtl/reg_wb_buf.sv
// One-entry result buffer between execute and write-back, with a REQ/ACK
// capture handshake and a pop that empties it on the write-back phase.
module reg_wb_buf
  import cpu15_pkg::*;
#(
  parameter int DATA_W = REG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [REG_NUM_W-1:0] req_n,
  input  logic [DATA_W-1:0]    req_data,
  input  logic                 pop,
  output logic                 ack,
  output logic                 buf_valid,
  output logic [REG_NUM_W-1:0] buf_n,
  output logic [DATA_W-1:0]    buf_data
);

  wb_state_e state;
  wb_state_e state_next;
  logic      capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WB_EMPTY;
      ack   <= 1'b0;
    end else begin
      state <= state_next;
      ack   <= capture;
    end
  end

  // Capture is gated by ack so a REQ still held during the ACK cycle is never
  // taken twice, even if the entry was already popped on that same edge.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      WB_EMPTY: begin
        if (req && !ack) begin
          capture    = 1'b1;
          state_next = WB_FULL;
        end
      end
      WB_FULL: begin
        if (pop) state_next = WB_EMPTY;
      end
      default: state_next = WB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_n    <= '0;
      buf_data <= '0;
    end else if (capture) begin
      buf_n    <= req_n;
      buf_data <= req_data;
    end
  end

  assign buf_valid = (state == WB_FULL);

endmodule

// File: rtl/reg_wb.sv
// cpu15 write-back stage: buffered result capture, 8-entry register file
// and per-register busy scoreboard for decode.
module reg_wb
  import cpu15_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int N_REGS = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 WB_PHASE,
  input  logic                 WB_REQ,
  input  logic [REG_NUM_W-1:0] N_REG_IN,
  input  logic [DATA_W-1:0]    DATA_IN,
  output logic                 WB_ACK,
  input  logic                 LOCK_SET,
  input  logic [REG_NUM_W-1:0] N_LOCK,
  output logic [N_REGS-1:0]    BUSY,
  output logic [DATA_W-1:0]    REG_0,
  output logic [DATA_W-1:0]    REG_1,
  output logic [DATA_W-1:0]    REG_2,
  output logic [DATA_W-1:0]    REG_3,
  output logic [DATA_W-1:0]    REG_4,
  output logic [DATA_W-1:0]    REG_5,
  output logic [DATA_W-1:0]    REG_6,
  output logic [DATA_W-1:0]    REG_7
);

  // The register index is 3 bits wide, so the file size cannot change.
  if (N_REGS != 8) begin : g_bad_n_regs
    $error("reg_wb: N_REGS must be 8");
  end

  logic                 buf_valid;
  logic [REG_NUM_W-1:0] buf_n;
  logic [DATA_W-1:0]    buf_data;
  logic                 write_en;
  logic [DATA_W-1:0]    regs [N_REGS];
  logic [N_REGS-1:0]    busy;
  logic [N_REGS-1:0]    busy_next;

  reg_wb_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .req      (WB_REQ),
    .req_n    (N_REG_IN),
    .req_data (DATA_IN),
    .pop      (WB_PHASE),
    .ack      (WB_ACK),
    .buf_valid(buf_valid),
    .buf_n    (buf_n),
    .buf_data (buf_data)
  );

  assign write_en = buf_valid && WB_PHASE;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[buf_n] <= buf_data;
    end
  end

  // A reservation on the same edge as a write to that register wins: it
  // belongs to a newer instruction than the result being retired.
  always_comb begin
    busy_next = busy;
    if (write_en) busy_next[buf_n] = 1'b0;
    if (LOCK_SET) busy_next[N_LOCK] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) busy <= '0;
    else          busy <= busy_next;
  end

  assign BUSY  = busy;
  assign REG_0 = regs[0];
  assign REG_1 = regs[1];
  assign REG_2 = regs[2];
  assign REG_3 = regs[3];
  assign REG_4 = regs[4];
  assign REG_5 = regs[5];
  assign REG_6 = regs[6];
  assign REG_7 = regs[7];

endmodule

// File: tb/tb_reg_wb.sv
// Directed bench for reg_wb: per-cycle vector table plus hand-written
// sequences for the held-request and mid-operation reset cases.
module tb_reg_wb;
  import cpu15_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_phase;
  logic        wb_req;
  logic [2:0]  n_reg;
  logic [15:0] data;
  logic        wb_ack;
  logic        lock_set;
  logic [2:0]  n_lock;
  logic [7:0]  busy;
  logic [15:0] reg_out [8];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        ph;
    logic        rq;
    logic [2:0]  n;
    logic [15:0] d;
    logic        lk;
    logic [2:0]  nl;
    logic        exp_ack;
    logic [7:0]  exp_busy;
    logic [2:0]  chk_reg;
    logic [15:0] exp_val;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vec [NVEC];

  reg_wb dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .WB_PHASE(wb_phase),
    .WB_REQ  (wb_req),
    .N_REG_IN(n_reg),
    .DATA_IN (data),
    .WB_ACK  (wb_ack),
    .LOCK_SET(lock_set),
    .N_LOCK  (n_lock),
    .BUSY    (busy),
    .REG_0   (reg_out[0]),
    .REG_1   (reg_out[1]),
    .REG_2   (reg_out[2]),
    .REG_3   (reg_out[3]),
    .REG_4   (reg_out[4]),
    .REG_5   (reg_out[5]),
    .REG_6   (reg_out[6]),
    .REG_7   (reg_out[7])
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic ph, logic rq, logic [2:0] n, logic [15:0] d,
                              logic lk, logic [2:0] nl, logic ack, logic [7:0] bsy,
                              logic [2:0] cr, logic [15:0] cv);
    vec_t v;
    v.ph = ph; v.rq = rq; v.n = n; v.d = d; v.lk = lk; v.nl = nl;
    v.exp_ack = ack; v.exp_busy = bsy; v.chk_reg = cr; v.exp_val = cv;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input logic ph, input logic rq, input logic [2:0] n,
                               input logic [15:0] d, input logic lk, input logic [2:0] nl);
    @(negedge clk);
    wb_phase = ph; wb_req = rq; n_reg = n; data = d; lock_set = lk; n_lock = nl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, expv);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"}, {15'd0, wb_ack}, 16'h0000);
    checkOutput({tag, "_busy"}, {8'd0, busy}, 16'h0000);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s_reg%0d", tag, i), reg_out[i], 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_phase = 1'b0; wb_req = 1'b0; n_reg = '0; data = '0; lock_set = 1'b0; n_lock = '0;

    vec[0]  = mk(0, 1, R3, 16'hBEEF, 0, R0, 1, 8'h00, R3, 16'h0000);
    vec[1]  = mk(0, 1, R3, 16'hBEEF, 0, R0, 0, 8'h00, R3, 16'h0000);
    vec[2]  = mk(1, 0, R0, 16'h0000, 0, R0, 0, 8'h00, R3, 16'hBEEF);
    vec[3]  = mk(0, 0, R0, 16'h0000, 0, R0, 0, 8'h00, R0, 16'h0000);
    vec[4]  = mk(0, 0, R0, 16'h0000, 1, R5, 0, 8'h20, R5, 16'h0000);
    vec[5]  = mk(0, 1, R5, 16'h1234, 0, R0, 1, 8'h20, R5, 16'h0000);
    vec[6]  = mk(0, 1, R5, 16'h1234, 0, R0, 0, 8'h20, R5, 16'h0000);
    vec[7]  = mk(1, 0, R0, 16'h0000, 0, R0, 0, 8'h00, R5, 16'h1234);
    vec[8]  = mk(0, 1, R2, 16'h7777, 0, R0, 1, 8'h00, R2, 16'h0000);
    vec[9]  = mk(0, 1, R2, 16'h7777, 0, R0, 0, 8'h00, R2, 16'h0000);
    vec[10] = mk(1, 0, R0, 16'h0000, 1, R2, 0, 8'h04, R2, 16'h7777);
    vec[11] = mk(0, 0, R0, 16'h0000, 0, R0, 0, 8'h04, R3, 16'hBEEF);
    vec[12] = mk(0, 1, R7, 16'hAAAA, 0, R0, 1, 8'h04, R7, 16'h0000);
    vec[13] = mk(1, 1, R7, 16'hAAAA, 0, R0, 0, 8'h04, R7, 16'hAAAA);
    vec[14] = mk(0, 1, R7, 16'h5555, 0, R0, 1, 8'h04, R7, 16'hAAAA);
    vec[15] = mk(0, 1, R7, 16'h5555, 0, R0, 0, 8'h04, R7, 16'hAAAA);
    vec[16] = mk(1, 0, R0, 16'h0000, 0, R0, 0, 8'h04, R7, 16'h5555);
    vec[17] = mk(0, 0, R0, 16'h0000, 1, R2, 0, 8'h04, R2, 16'h7777);

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vec[i].ph, vec[i].rq, vec[i].n, vec[i].d, vec[i].lk, vec[i].nl);
      checkOutput($sformatf("v%0d_ack", i), {15'd0, wb_ack}, {15'd0, vec[i].exp_ack});
      checkOutput($sformatf("v%0d_busy", i), {8'd0, busy}, {8'd0, vec[i].exp_busy});
      checkOutput($sformatf("v%0d_reg%0d", i, vec[i].chk_reg), reg_out[vec[i].chk_reg], vec[i].exp_val);
    end
    checkOutput("final_reg4", reg_out[4], 16'h0000);

    // Buffer full with reg1; a second request for reg6 must wait for the phase.
    applyStimulus(0, 1, R1, 16'h1111, 0, R0);
    checkOutput("hold_ack1", {15'd0, wb_ack}, 16'h0001);
    applyStimulus(0, 1, R1, 16'h1111, 0, R0);
    checkOutput("hold_ack1_drop", {15'd0, wb_ack}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, R6, 16'h00FF, 0, R0);
      checkOutput($sformatf("hold_noack%0d", i), {15'd0, wb_ack}, 16'h0000);
      checkOutput($sformatf("hold_reg1_%0d", i), reg_out[1], 16'h0000);
    end
    applyStimulus(1, 1, R6, 16'h00FF, 0, R0);
    checkOutput("hold_wr_ack", {15'd0, wb_ack}, 16'h0000);
    checkOutput("hold_reg1", reg_out[1], 16'h1111);
    applyStimulus(0, 1, R6, 16'h00FF, 0, R0);
    checkOutput("hold_ack6", {15'd0, wb_ack}, 16'h0001);
    applyStimulus(0, 1, R6, 16'h00FF, 0, R0);
    checkOutput("hold_ack6_drop", {15'd0, wb_ack}, 16'h0000);
    applyStimulus(0, 0, R0, 16'h0000, 0, R0);
    checkOutput("hold_reg6_pre", reg_out[6], 16'h0000);
    applyStimulus(1, 0, R0, 16'h0000, 0, R0);
    checkOutput("hold_reg6", reg_out[6], 16'h00FF);
    checkOutput("hold_busy", {8'd0, busy}, 16'h0004);

    // Reset mid-operation discards the buffered reg4 write.
    applyStimulus(0, 0, R0, 16'h0000, 1, R4);
    checkOutput("rst_busy_pre", {8'd0, busy}, 16'h0014);
    applyStimulus(0, 1, R4, 16'hCAFE, 0, R0);
    checkOutput("rst_ack_pre", {15'd0, wb_ack}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    wb_req = 1'b0; data = '0; n_reg = '0;
    rst_n = 1'b1;
    applyStimulus(0, 0, R0, 16'h0000, 0, R0);
    applyStimulus(1, 0, R0, 16'h0000, 0, R0);
    checkOutput("post_rst_reg4", reg_out[4], 16'h0000);
    checkOutput("post_rst_ack", {15'd0, wb_ack}, 16'h0000);
    checkOutput("post_rst_busy", {8'd0, busy}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
